// File: rtl/alu_result_queue.sv
// alu_result_queue: buffers ALU results plus derived {ovf,neg,zero} flags for writeback.
// Define ALU_STICKY_OVF_EN to add the ovf_clr input and the ovf_sticky output.
module alu_result_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [2:0]       in_gin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [2:0]       out_flag,
  output logic [2:0]       cc_flag,
  output logic [CW-1:0]    count
`ifdef ALU_STICKY_OVF_EN
  ,
  input  logic             ovf_clr,
  output logic             ovf_sticky
`endif
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned Msb = WIDTH - 1;
  localparam logic [2:0] GinAdd = 3'b010;
  localparam logic [2:0] GinSub = 3'b110;

  logic [WIDTH-1:0] sum_mem_q  [DEPTH];
  logic [2:0]       flag_mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2:0]       cc_q, cc_d;
  logic             enq, deq;
  logic             in_ovf;
  logic [2:0]       in_flag;
  logic [2:0]       head_flag;

  // Only operand sign bits feed overflow detection.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{in_a[Msb-1:0], in_b[Msb-1:0]};

  always_comb begin
    in_ovf = 1'b0;
    case (in_gin)
      GinAdd:  in_ovf = (in_a[Msb] == in_b[Msb]) && (in_sum[Msb] != in_a[Msb]);
      GinSub:  in_ovf = (in_a[Msb] != in_b[Msb]) && (in_sum[Msb] != in_a[Msb]);
      default: in_ovf = 1'b0;
    endcase
  end

  assign in_flag = {in_ovf, in_sum[Msb], (in_sum == '0)};

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  assign head_flag = flag_mem_q[rd_ptr_q];
  assign out_sum   = out_valid ? sum_mem_q[rd_ptr_q] : '0;
  assign out_flag  = out_valid ? head_flag : '0;
  assign cc_flag   = cc_q;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cc_d     = cc_q;
    if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
    if (deq) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      cc_d     = head_flag;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cc_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cc_q     <= cc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sum_mem_q[i]  <= '0;
        flag_mem_q[i] <= '0;
      end
    end else if (enq) begin
      sum_mem_q[wr_ptr_q]  <= in_sum;
      flag_mem_q[wr_ptr_q] <= in_flag;
    end
  end

`ifdef ALU_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // A dequeued overflow outranks a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (deq && head_flag[2]) sticky_d = 1'b1;
    else if (ovf_clr)        sticky_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign ovf_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// Self-checking bench for alu_result_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_alu_result_queue;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [2:0]  flag;
    logic [31:0] sum;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0, in_sum = '0;
  logic [2:0]  in_gin = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic [2:0]  out_flag;
  logic [2:0]  cc_flag;
  logic [1:0]  count;
  logic        ovf_clr = 1'b0;
  logic        ovf_sticky;

  entry_t      model_q[$];
  logic [2:0]  model_cc = '0;
  logic        model_sticky = 1'b0;
  int          total = 0;
  int          bad = 0;

  alu_result_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sum    (in_sum),
    .in_gin    (in_gin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_flag  (out_flag),
    .cc_flag   (cc_flag),
    .count     (count)
`ifdef ALU_STICKY_OVF_EN
    ,
    .ovf_clr   (ovf_clr),
    .ovf_sticky(ovf_sticky)
`endif
  );

`ifndef ALU_STICKY_OVF_EN
  assign ovf_sticky = 1'b0;
`endif

  always #5 clk = ~clk;

  // Flags from arithmetic meaning: overflow when the true signed result leaves 32-bit range.
  function automatic logic [2:0] ref_flag(logic [31:0] a, logic [31:0] b, logic [31:0] s,
                                          logic [2:0] g);
    longint r;
    logic   ovf;
    ovf = 1'b0;
    if (g == 3'b010 || g == 3'b110) begin
      if (g == 3'b010) r = longint'($signed(a)) + longint'($signed(b));
      else             r = longint'($signed(a)) - longint'($signed(b));
      ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    end
    return {ovf, s[31], (s == 32'd0)};
  endfunction

  // Advance one clock edge, updating the model from the inputs presented before the edge.
  task automatic tick();
    bit     enq, deq;
    entry_t head;
    enq = in_valid && (model_q.size() < DEPTH);
    deq = out_ready && (model_q.size() != 0);
    @(posedge clk);
    if (deq) begin
      head = model_q.pop_front();
      model_cc = head.flag;
      if (head.flag[2]) model_sticky = 1'b1;
      else if (ovf_clr) model_sticky = 1'b0;
    end else if (ovf_clr) begin
      model_sticky = 1'b0;
    end
    if (enq) model_q.push_back({ref_flag(in_a, in_b, in_sum, in_gin), in_sum});
    #1;
  endtask

  task automatic push(logic [31:0] a, logic [31:0] b, logic [31:0] s, logic [2:0] g);
    in_valid = 1'b1; in_a = a; in_b = b; in_sum = s; in_gin = g;
  endtask

  task automatic test_reset();
    total++; if (count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_sum !== 32'd0) begin bad++; $display("FAIL reset_out_sum got=%h want=0", out_sum); end
    total++; if (out_flag !== 3'b000) begin bad++; $display("FAIL reset_out_flag got=%b want=000", out_flag); end
    total++; if (cc_flag !== 3'b000) begin bad++; $display("FAIL reset_cc_flag got=%b want=000", cc_flag); end
  endtask

  task automatic test_add_ovf();
    out_ready = 1'b0;
    push(32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 3'b010);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", out_valid); end
    total++; if (out_sum !== 32'h8000_0000) begin bad++; $display("FAIL add_sum got=%h want=80000000", out_sum); end
    total++; if (out_flag !== 3'b110) begin bad++; $display("FAIL add_flag got=%b want=110", out_flag); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (cc_flag !== 3'b110) begin bad++; $display("FAIL add_cc got=%b want=110", cc_flag); end
    total++; if (count !== 2'd0) begin bad++; $display("FAIL add_count got=%0d want=0", count); end
    total++; if (out_sum !== 32'd0) begin bad++; $display("FAIL add_empty_sum got=%h want=0", out_sum); end
  endtask

  task automatic test_sub_zero();
    out_ready = 1'b0;
    push(32'd5, 32'd5, 32'd0, 3'b110);
    tick();
    push(32'd5, 32'd5, 32'd0, 3'b000);
    tick();
    in_valid = 1'b0;
    total++; if (count !== 2'd2) begin bad++; $display("FAIL sub_count got=%0d want=2", count); end
    total++; if (out_flag !== 3'b001) begin bad++; $display("FAIL sub_flag got=%b want=001", out_flag); end
    out_ready = 1'b1;
    tick();
    total++; if (cc_flag !== 3'b001) begin bad++; $display("FAIL sub_cc got=%b want=001", cc_flag); end
    total++; if (out_flag !== 3'b001) begin bad++; $display("FAIL nop_flag got=%b want=001", out_flag); end
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sub_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_full();
    int          next_k;
    int          accepted;
    logic [31:0] seen[$];
    out_ready = 1'b0;
    next_k = 1;
    for (int i = 0; i < 3; i++) begin
      push(32'd1, 32'd2, 32'(11 * next_k), 3'b000);
      if (in_ready) next_k++;
      tick();
    end
    total++; if (count !== 2'd2) begin bad++; $display("FAIL full_count got=%0d want=2", count); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
    total++; if (out_sum !== 32'd11) begin bad++; $display("FAIL full_head got=%0d want=11", out_sum); end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(32'd1, 32'd2, 32'(11 * next_k), 3'b000);
      if (in_ready) next_k++;
      if (out_valid) seen.push_back(out_sum);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid) seen.push_back(out_sum);
      tick();
    end
    out_ready = 1'b0;
    accepted = next_k - 1;
    total++;
    if (seen.size() != accepted) begin
      bad++; $display("FAIL full_stream_len got=%0d want=%0d", seen.size(), accepted);
    end
    foreach (seen[i]) begin
      total++;
      if (seen[i] !== 32'(11 * (i + 1))) begin
        bad++; $display("FAIL full_order idx=%0d got=%0d want=%0d", i, seen[i], 11 * (i + 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    push(32'd0, 32'd0, 32'd100, 3'b000);
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push(32'd0, 32'd0, 32'(100 + i), 3'b000);
      tick();
      total++; if (count !== 2'd1) begin bad++; $display("FAIL b2b_count cyc=%0d got=%0d want=1", i, count); end
      total++;
      if (out_sum !== 32'(100 + i)) begin
        bad++; $display("FAIL b2b_head cyc=%0d got=%0d want=%0d", i, out_sum, 100 + i);
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    total++; if (count !== 2'd0) begin bad++; $display("FAIL b2b_drain got=%0d want=0", count); end
  endtask

  task automatic test_sticky();
`ifdef ALU_STICKY_OVF_EN
    out_ready = 1'b0;
    push(32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 3'b010);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    ovf_clr = 1'b1;
    tick();
    total++; if (ovf_sticky !== 1'b1) begin bad++; $display("FAIL sticky_set_wins got=%b want=1", ovf_sticky); end
    out_ready = 1'b0;
    tick();
    ovf_clr = 1'b0;
    total++; if (ovf_sticky !== 1'b0) begin bad++; $display("FAIL sticky_clear got=%b want=0", ovf_sticky); end
`endif
  endtask

  task automatic test_random();
    int          sel;
    logic [2:0]  g;
    logic [31:0] a, b;
    for (int i = 0; i < 400; i++) begin
      a = $urandom();
      b = $urandom();
      sel = $urandom_range(0, 2);
      if (sel == 0) push(a, b, a + b, 3'b010);
      else if (sel == 1) push(a, b, a - b, 3'b110);
      else begin
        g = 3'($urandom_range(0, 7));
        if (g == 3'b010 || g == 3'b110) g = 3'b001;
        push(a, b, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom(), g);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 6);
      ovf_clr   = ($urandom_range(0, 9) == 0);
      tick();
      total++;
      if (count !== 2'(model_q.size())) begin
        bad++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", i, count, model_q.size());
      end
      total++;
      if (out_valid !== (model_q.size() != 0) || in_ready !== (model_q.size() != DEPTH)) begin
        bad++; $display("FAIL rnd_hs cyc=%0d got=%b%b want=%b%b", i, out_valid, in_ready,
                        model_q.size() != 0, model_q.size() != DEPTH);
      end
      total++;
      if (model_q.size() != 0 ? ({out_flag, out_sum} !== model_q[0])
                              : ({out_flag, out_sum} !== 35'd0)) begin
        bad++; $display("FAIL rnd_head cyc=%0d got=%b/%h want=%h", i, out_flag, out_sum,
                        model_q.size() != 0 ? model_q[0] : 35'd0);
      end
      total++;
      if (cc_flag !== model_cc) begin
        bad++; $display("FAIL rnd_cc cyc=%0d got=%b want=%b", i, cc_flag, model_cc);
      end
`ifdef ALU_STICKY_OVF_EN
      total++;
      if (ovf_sticky !== model_sticky) begin
        bad++; $display("FAIL rnd_sticky cyc=%0d got=%b want=%b", i, ovf_sticky, model_sticky);
      end
`endif
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    push(32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 3'b010);
    out_ready = (model_q.size() != 0);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    push(32'd3, 32'd4, 32'd7, 3'b010);
    tick();
    push(32'd9, 32'd1, 32'd8, 3'b110);
    tick();
    in_valid = 1'b0;
    total++; if (count !== 2'd2) begin bad++; $display("FAIL rmid_pre_count got=%0d want=2", count); end
    total++; if (cc_flag !== 3'b110) begin bad++; $display("FAIL rmid_pre_cc got=%b want=110", cc_flag); end
    rst_n = 1'b0;
    #1;
    model_q.delete();
    model_cc = '0;
    model_sticky = 1'b0;
    total++; if (count !== 2'd0) begin bad++; $display("FAIL rmid_count got=%0d want=0", count); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%b want=0", out_valid); end
    total++; if (cc_flag !== 3'b000) begin bad++; $display("FAIL rmid_cc got=%b want=000", cc_flag); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
    rst_n = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_post got=%b want=0", out_valid); end
  endtask

  initial begin
    #12;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_add_ovf();
    test_sub_zero();
    test_full();
    test_back_to_back();
    test_sticky();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
